// File: rtl/fetch_decode_reg.sv
// Fetch/decode pipeline register with a one-entry skid buffer,
// a HALT freeze state and a saturating stall counter.
module fetch_decode_reg #(
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr_IF,
  input  logic [15:0] pcPlus2_IF,
  input  logic        instrValid_IF,
  input  logic        stall,
  input  logic        flush,
  output logic [15:0] instr_FD,
  output logic [15:0] pcPlus2_FD,
  output logic        valid_FD,
  output logic        pcWriteEn,
  output logic        halted,
  output logic [7:0]  stallCnt
);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    SKID = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_instr;
  logic [15:0] r_pc;
  logic        r_valid;
  logic [15:0] r_skid_instr;
  logic [15:0] r_skid_pc;
  logic [7:0]  r_stall_cnt;

  logic [15:0] w_instr_nxt;
  logic [15:0] w_pc_nxt;
  logic        w_valid_nxt;
  logic [15:0] w_skid_instr_nxt;
  logic [15:0] w_skid_pc_nxt;
  logic        w_fetch_halt;
  logic        w_skid_halt;

  // HALT opcode: top five bits all zero
  assign w_fetch_halt = (instr_IF[15:11] == 5'b00000);
  assign w_skid_halt  = (r_skid_instr[15:11] == 5'b00000);

  // Next FD contents, skid contents and state (flush > stall > load)
  always_comb begin
    w_state_nxt      = r_state;
    w_instr_nxt      = r_instr;
    w_pc_nxt         = r_pc;
    w_valid_nxt      = r_valid;
    w_skid_instr_nxt = r_skid_instr;
    w_skid_pc_nxt    = r_skid_pc;
    if (flush) begin
      w_instr_nxt      = NOP_INSTR;
      w_valid_nxt      = 1'b0;
      w_skid_instr_nxt = 16'h0000;
      w_skid_pc_nxt    = 16'h0000;
      w_state_nxt      = RUN;
    end else if (stall) begin
      if (r_state == RUN && instrValid_IF) begin
        w_skid_instr_nxt = instr_IF;
        w_skid_pc_nxt    = pcPlus2_IF;
        w_state_nxt      = SKID;
      end
    end else begin
      unique case (r_state)
        RUN: begin
          if (instrValid_IF) begin
            w_instr_nxt = instr_IF;
            w_pc_nxt    = pcPlus2_IF;
            w_valid_nxt = 1'b1;
            w_state_nxt = w_fetch_halt ? HALT : RUN;
          end else begin
            w_instr_nxt = NOP_INSTR;
            w_valid_nxt = 1'b0;
          end
        end
        SKID: begin
          w_instr_nxt      = r_skid_instr;
          w_pc_nxt         = r_skid_pc;
          w_valid_nxt      = 1'b1;
          w_skid_instr_nxt = 16'h0000;
          w_skid_pc_nxt    = 16'h0000;
          w_state_nxt      = w_skid_halt ? HALT : RUN;
        end
        HALT: begin
          w_state_nxt = HALT;
        end
        default: begin
          w_state_nxt = RUN;
        end
      endcase
    end
  end

  // State, FD and skid registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= RUN;
      r_instr      <= NOP_INSTR;
      r_pc         <= 16'h0000;
      r_valid      <= 1'b0;
      r_skid_instr <= 16'h0000;
      r_skid_pc    <= 16'h0000;
    end else begin
      r_state      <= w_state_nxt;
      r_instr      <= w_instr_nxt;
      r_pc         <= w_pc_nxt;
      r_valid      <= w_valid_nxt;
      r_skid_instr <= w_skid_instr_nxt;
      r_skid_pc    <= w_skid_pc_nxt;
    end
  end

  // Saturating count of stalled cycles, counts even when flush wins
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= 8'h00;
    end else if (stall && r_stall_cnt != 8'hFF) begin
      r_stall_cnt <= r_stall_cnt + 8'h01;
    end
  end

  assign pcWriteEn  = !rst &&
                      (flush || (instrValid_IF && r_state == RUN));
  assign instr_FD   = r_instr;
  assign pcPlus2_FD = r_pc;
  assign valid_FD   = r_valid;
  assign halted     = (r_state == HALT);
  assign stallCnt   = r_stall_cnt;

endmodule

// File: tb/tb_fetch_decode_reg.sv
// Scoreboard bench for fetch_decode_reg: driver queues expected
// results, monitor pops and compares them against the DUT.
module tb_fetch_decode_reg;

  logic        clk;
  logic        rst;
  logic [15:0] instr_IF;
  logic [15:0] pcPlus2_IF;
  logic        instrValid_IF;
  logic        stall;
  logic        flush;
  logic [15:0] instr_FD;
  logic [15:0] pcPlus2_FD;
  logic        valid_FD;
  logic        pcWriteEn;
  logic        halted;
  logic [7:0]  stallCnt;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] pc;
    logic        valid;
    logic        halted;
    logic [7:0]  cnt;
    logic        pwe;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  fetch_decode_reg #(.NOP_INSTR(16'h0800)) dut (
    .clk           (clk),
    .rst           (rst),
    .instr_IF      (instr_IF),
    .pcPlus2_IF    (pcPlus2_IF),
    .instrValid_IF (instrValid_IF),
    .stall         (stall),
    .flush         (flush),
    .instr_FD      (instr_FD),
    .pcPlus2_FD    (pcPlus2_FD),
    .valid_FD      (valid_FD),
    .pcWriteEn     (pcWriteEn),
    .halted        (halted),
    .stallCnt      (stallCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs and queue the expected response
  task automatic step(input logic r, input logic f,
                      input logic s, input logic v,
                      input logic [15:0] i, input logic [15:0] p,
                      input logic [15:0] ei, input logic [15:0] ep,
                      input logic ev, input logic eh,
                      input logic [7:0] ec, input logic epwe);
    exp_t e;
    @(negedge clk);
    rst           = r;
    flush         = f;
    stall         = s;
    instrValid_IF = v;
    instr_IF      = i;
    pcPlus2_IF    = p;
    e.instr  = ei;
    e.pc     = ep;
    e.valid  = ev;
    e.halted = eh;
    e.cnt    = ec;
    e.pwe    = epwe;
    q.push_back(e);
  endtask

  // Monitor: pcWriteEn before the edge, registers after it
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pcWriteEn", {15'd0, pcWriteEn}, {15'd0, e.pwe});
        @(posedge clk);
        #1;
        chk("instr_FD", instr_FD, e.instr);
        chk("pcPlus2_FD", pcPlus2_FD, e.pc);
        chk("valid_FD", {15'd0, valid_FD}, {15'd0, e.valid});
        chk("halted", {15'd0, halted}, {15'd0, e.halted});
        chk("stallCnt", {8'd0, stallCnt}, {8'd0, e.cnt});
      end
    end
  end

  initial begin
    int n;
    rst = 1'b1; flush = 1'b0; stall = 1'b0;
    instrValid_IF = 1'b0;
    instr_IF = 16'h0000; pcPlus2_IF = 16'h0000;
    // reset overrides flush/stall/valid
    step(1,1,1,1,16'h1111,16'h0002, 16'h0800,16'h0000,0,0,8'd0,0);
    // normal flow
    step(0,0,0,1,16'h4123,16'h0002, 16'h4123,16'h0002,1,0,8'd0,1);
    // stall with fetch return -> SKID
    step(0,0,1,1,16'hC0FF,16'h0004, 16'h4123,16'h0002,1,0,8'd1,1);
    step(0,0,1,1,16'hAAAA,16'h0006, 16'h4123,16'h0002,1,0,8'd2,0);
    step(0,0,1,0,16'h0000,16'h0000, 16'h4123,16'h0002,1,0,8'd3,0);
    // release: skid drains, fetch ignored
    step(0,0,0,1,16'hBBBB,16'h0008, 16'hC0FF,16'h0004,1,0,8'd3,0);
    // fetch bubble
    step(0,0,0,0,16'h0000,16'h0000, 16'h0800,16'h0004,0,0,8'd3,0);
    // flush mid-SKID
    step(0,0,1,1,16'h1234,16'h000A, 16'h0800,16'h0004,0,0,8'd4,1);
    step(0,1,1,0,16'h0000,16'h0000, 16'h0800,16'h0004,0,0,8'd5,1);
    step(0,0,0,0,16'h0000,16'h0000, 16'h0800,16'h0004,0,0,8'd5,0);
    // HALT freeze and flush exit
    step(0,0,0,1,16'h0000,16'h0010, 16'h0000,16'h0010,1,1,8'd5,1);
    step(0,0,0,1,16'h5555,16'h0012, 16'h0000,16'h0010,1,1,8'd5,0);
    step(0,0,1,1,16'h6666,16'h0014, 16'h0000,16'h0010,1,1,8'd6,0);
    step(0,1,0,0,16'h0000,16'h0000, 16'h0800,16'h0010,0,0,8'd6,1);
    // HALT reached from the skid buffer
    step(0,0,1,1,16'h07FF,16'h0020, 16'h0800,16'h0010,0,0,8'd7,1);
    step(0,0,0,1,16'h7777,16'h0022, 16'h07FF,16'h0020,1,1,8'd7,0);
    // reset while halted
    step(1,0,0,1,16'h8888,16'h0024, 16'h0800,16'h0000,0,0,8'd0,0);
    // non-HALT opcode with high bits set
    step(0,0,0,1,16'hF800,16'h0030, 16'hF800,16'h0030,1,0,8'd0,1);
    // counter saturation over 300 stalled cycles
    for (int k = 0; k < 300; k++) begin
      n = (k + 1 > 255) ? 255 : k + 1;
      step(0,0,1,0,16'h0000,16'h0000,
           16'hF800,16'h0030,1,0,n[7:0],0);
    end
    // reset clears everything
    step(1,0,0,0,16'h0000,16'h0000, 16'h0800,16'h0000,0,0,8'd0,0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, required 0", q.size());
    end
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
